// File: rtl/icache_mem_ctrl.sv
// Instruction-side RAM controller for two cores: round-robin arbitration,
// one outstanding word fetch at a time, abortable while the RAM access is pending.
module icache_mem_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        iREN,
  input  logic [WORD_W-1:0] iaddr0,
  input  logic [WORD_W-1:0] iaddr1,
  output logic [1:0]        iwait,
  output logic [WORD_W-1:0] iload0,
  output logic [WORD_W-1:0] iload1,
  input  logic              dbusy,
  output logic              ramREN,
  output logic [WORD_W-1:0] ramaddr,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              last_grant_reg, last_grant_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] data_reg, data_next;

  logic              req_grant;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] held_addr;

  // On a tie the core that did not win last time gets the grant.
  assign req_grant = (iREN == 2'b11) ? ~last_grant_reg : iREN[1];
  assign req_addr  = req_grant ? {iaddr1[WORD_W-1:2], 2'b00} : {iaddr0[WORD_W-1:2], 2'b00};
  assign held_addr = grant_reg ? {iaddr1[WORD_W-1:2], 2'b00} : {iaddr0[WORD_W-1:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      data_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    unique case (state_reg)
      IDLE: begin
        if (!dbusy && (iREN != 2'b00)) begin
          grant_next = req_grant;
          addr_next  = req_addr;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn or redirected request wins over data arriving in the same cycle.
        if (!iREN[grant_reg] || (held_addr != addr_reg)) begin
          state_next = IDLE;
        end else if (ramready) begin
          data_next  = ramload;
          state_next = DONE;
        end
      end
      DONE: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ramREN  = (state_reg == ISSUE);
  assign ramaddr = (state_reg == ISSUE) ? addr_reg : '0;
  assign iload0  = data_reg;
  assign iload1  = data_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_iwait
    assign iwait[gi] = !((state_reg == DONE) && (grant_reg == 1'(gi)));
  end

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Directed bench for icache_mem_ctrl: inputs driven and outputs sampled on the
// falling edge, so each check sees the registered state of the current cycle.
module tb_icache_mem_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN;
  logic [31:0] iaddr0, iaddr1;
  logic [1:0]  iwait;
  logic [31:0] iload0, iload1;
  logic        dbusy;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  logic        ramready;

  int compared   = 0;
  int mismatched = 0;

  icache_mem_ctrl #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .iwait(iwait), .iload0(iload0), .iload1(iload1), .dbusy(dbusy),
    .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    nRST = 1'b0; iREN = 2'b00; iaddr0 = '0; iaddr1 = '0;
    dbusy = 1'b0; ramload = '0; ramready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 2'b11; iaddr0 = 32'h40; iaddr1 = 32'h80;
    dbusy = 1'b0; ramload = 32'hFFFF_FFFF; ramready = 1'b1;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b11) begin mismatched++; $display("FAIL reset_iwait got=%b exp=11", iwait); end
    compared++;
    if (iload0 !== 32'h0 || iload1 !== 32'h0) begin
      mismatched++; $display("FAIL reset_iload got=%h/%h exp=0/0", iload0, iload1);
    end
    compared++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
      mismatched++; $display("FAIL reset_ram got ren=%b addr=%h exp ren=0 addr=0", ramREN, ramaddr);
    end
    $display("reset: iwait=%b iload0=%h ramREN=%b ramaddr=%h", iwait, iload0, ramREN, ramaddr);
  endtask

  task automatic test_basic();
    do_reset();
    iREN = 2'b01; iaddr0 = 32'h40;
    @(negedge CLK);
    compared++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      mismatched++; $display("FAIL basic_issue got ren=%b addr=%h exp ren=1 addr=40", ramREN, ramaddr);
    end
    compared++;
    if (iwait !== 2'b11) begin mismatched++; $display("FAIL basic_issue_iwait got=%b exp=11", iwait); end
    ramready = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b10 || iload0 !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL basic_done got iwait=%b iload0=%h exp 10/deadbeef", iwait, iload0);
    end
    compared++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
      mismatched++; $display("FAIL basic_done_ram got ren=%b addr=%h exp 0/0", ramREN, ramaddr);
    end
    $display("basic: core0 fetch 0x40 -> iwait=%b iload0=%h", iwait, iload0);
    ramready = 1'b0; iREN = 2'b00;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b11) begin mismatched++; $display("FAIL basic_after got iwait=%b exp=11", iwait); end
  endtask

  task automatic test_round_robin();
    logic       g;
    logic [1:0] exp_wait;
    logic [31:0] exp_addr;
    do_reset();
    iREN = 2'b11; iaddr0 = 32'h100; iaddr1 = 32'h200; ramready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g        = i[0];
      exp_addr = g ? 32'h200 : 32'h100;
      exp_wait = g ? 2'b01 : 2'b10;
      @(negedge CLK);
      compared++;
      if (ramREN !== 1'b1 || ramaddr !== exp_addr) begin
        mismatched++; $display("FAIL rr_issue%0d got ren=%b addr=%h exp ren=1 addr=%h", i, ramREN, ramaddr, exp_addr);
      end
      ramload = 32'h1000 + i;
      @(negedge CLK);
      compared++;
      if (iwait !== exp_wait || iload0 !== 32'h1000 + i || iload1 !== 32'h1000 + i) begin
        mismatched++;
        $display("FAIL rr_done%0d got iwait=%b iload=%h exp iwait=%b iload=%h", i, iwait, iload0, exp_wait, 32'h1000 + i);
      end
      $display("rr: fetch %0d grant=%0d iwait=%b iload=%h", i, g, iwait, iload0);
      @(negedge CLK);
      compared++;
      if (iwait !== 2'b11 || ramREN !== 1'b0) begin
        mismatched++; $display("FAIL rr_idle%0d got iwait=%b ren=%b exp 11/0", i, iwait, ramREN);
      end
    end
    iREN = 2'b00; ramready = 1'b0;
  endtask

  task automatic test_dbusy();
    do_reset();
    iREN = 2'b10; iaddr1 = 32'h80; dbusy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      compared++;
      if (ramREN !== 1'b0 || iwait !== 2'b11) begin
        mismatched++; $display("FAIL dbusy_hold%0d got ren=%b iwait=%b exp 0/11", k, ramREN, iwait);
      end
    end
    dbusy = 1'b0;
    @(negedge CLK);
    compared++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
      mismatched++; $display("FAIL dbusy_issue got ren=%b addr=%h exp 1/80", ramREN, ramaddr);
    end
    dbusy = 1'b1; ramready = 1'b1; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b01 || iload1 !== 32'hCAFEF00D) begin
      mismatched++; $display("FAIL dbusy_done got iwait=%b iload1=%h exp 01/cafef00d", iwait, iload1);
    end
    $display("dbusy: core1 fetch 0x80 -> iwait=%b iload1=%h", iwait, iload1);
    dbusy = 1'b0; ramready = 1'b0; iREN = 2'b00;
  endtask

  task automatic test_abort();
    do_reset();
    iREN = 2'b01; iaddr0 = 32'h40;
    @(negedge CLK);
    compared++;
    if (ramaddr !== 32'h40) begin mismatched++; $display("FAIL abort_issue got addr=%h exp=40", ramaddr); end
    iaddr0 = 32'h44; ramready = 1'b1; ramload = 32'hBAD0BAD0;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b11 || ramREN !== 1'b0) begin
      mismatched++; $display("FAIL abort_idle got iwait=%b ren=%b exp 11/0", iwait, ramREN);
    end
    ramready = 1'b0;
    @(negedge CLK);
    compared++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
      mismatched++; $display("FAIL abort_regrant got ren=%b addr=%h exp 1/44", ramREN, ramaddr);
    end
    ramready = 1'b1; ramload = 32'h12345678;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b10 || iload0 !== 32'h12345678) begin
      mismatched++; $display("FAIL abort_done got iwait=%b iload0=%h exp 10/12345678", iwait, iload0);
    end
    $display("abort: redirect 0x40->0x44 -> iwait=%b iload0=%h", iwait, iload0);
    ramready = 1'b0; iREN = 2'b00;
    // Withdrawn request: dropping iREN mid-access must also abort.
    @(negedge CLK);
    iREN = 2'b10; iaddr1 = 32'h300;
    @(negedge CLK);
    iREN = 2'b00; ramready = 1'b1;
    @(negedge CLK);
    compared++;
    if (iwait !== 2'b11 || ramREN !== 1'b0) begin
      mismatched++; $display("FAIL abort_withdraw got iwait=%b ren=%b exp 11/0", iwait, ramREN);
    end
    ramready = 1'b0;
  endtask

  task automatic test_align();
    do_reset();
    iREN = 2'b01; iaddr0 = 32'h43;
    @(negedge CLK);
    compared++;
    if (ramaddr !== 32'h40) begin mismatched++; $display("FAIL align0 got addr=%h exp=40", ramaddr); end
    $display("align: iaddr0=0x43 -> ramaddr=%h", ramaddr);
    iREN = 2'b00;
    @(negedge CLK);
    iREN = 2'b10; iaddr1 = 32'h1237;
    @(negedge CLK);
    compared++;
    if (ramaddr !== 32'h1234) begin mismatched++; $display("FAIL align1 got addr=%h exp=1234", ramaddr); end
    $display("align: iaddr1=0x1237 -> ramaddr=%h", ramaddr);
    iREN = 2'b00;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    iREN = 2'b01; iaddr0 = 32'h40;
    @(negedge CLK);
    compared++;
    if (ramREN !== 1'b1) begin mismatched++; $display("FAIL rst_mid_issue got ren=%b exp=1", ramREN); end
    #1 nRST = 1'b0; iREN = 2'b00;
    #1;
    compared++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
      mismatched++; $display("FAIL rst_mid_async got ren=%b addr=%h exp 0/0", ramREN, ramaddr);
    end
    @(negedge CLK);
    nRST = 1'b1; ramready = 1'b1; ramload = 32'h55AA55AA;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      compared++;
      if (iwait !== 2'b11 || ramREN !== 1'b0) begin
        mismatched++; $display("FAIL rst_mid_after%0d got iwait=%b ren=%b exp 11/0", k, iwait, ramREN);
      end
    end
    $display("rst_mid: after release iwait=%b ramREN=%b", iwait, ramREN);
    ramready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_dbusy();
    test_abort();
    test_align();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/icache_mem_ctrl.md
ICACHE_MEM_CTRL -- requirements
Module: icache_mem_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning address and instruction word width.
REQ-002 SHALL have port CLK  input  1  system clock, rising-edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREN  input  2  per-core icache read request; bit k is core k.
REQ-005 SHALL have port iaddr0  input  WORD_W  core 0 fetch address.
REQ-006 SHALL have port iaddr1  input  WORD_W  core 1 fetch address.
REQ-007 SHALL have port iwait  output  2  per-core stall; bit k low means iload{k} is valid this cycle.
REQ-008 SHALL have port iload0  output  WORD_W  instruction word returned to core 0.
REQ-009 SHALL have port iload1  output  WORD_W  instruction word returned to core 1.
REQ-010 SHALL have port dbusy  input  1  data-side controller owns RAM; blocks new instruction grants.
REQ-011 SHALL have port ramREN  output  1  RAM read enable.
REQ-012 SHALL have port ramaddr  output  WORD_W  RAM word address.
REQ-013 SHALL have port ramload  input  WORD_W  RAM read data.
REQ-014 SHALL have port ramready  input  1  one-cycle pulse: ramload valid.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DONE; encoding free.
REQ-016 IDLE: if dbusy=0 and iREN!=0, SHALL latch grant index g and word-aligned address {iaddr_g[WORD_W-1:2],2'b00}, next state ISSUE; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: one requester -> grant it; both -> grant ~last_grant.
REQ-018 dbusy SHALL be sampled only in IDLE; dbusy rising during ISSUE/DONE SHALL NOT preempt.
REQ-019 ISSUE: ramREN=1, ramaddr=latched address, held stable every ISSUE cycle.
REQ-020 ISSUE with ramready=1 SHALL capture ramload into data register, next state DONE.
REQ-021 ISSUE abort: if iREN[g]=0, or iaddr_g aligned differs from latched address, in any ISSUE cycle, SHALL go IDLE with no DONE, no last_grant update; abort takes priority over ramready in same cycle.
REQ-022 DONE: iwait[g]=0 for exactly one cycle; last_grant<=g; next state IDLE unconditionally; ramREN=0.
REQ-023 iwait[k] SHALL be 1 in every cycle except DONE with g=k; never both bits low.
REQ-024 iload0 and iload1 SHALL both drive the data register continuously; consumers use only when own iwait low.
REQ-025 ramREN and ramaddr SHALL be 0 outside ISSUE.
REQ-026 Minimum latency: request seen in IDLE cycle N, ramready in cycle N+1 -> iwait[g] low in cycle N+2.
REQ-027 Request held after DONE SHALL be re-arbitrated in the following IDLE cycle (back-to-back fetches take >=3 cycles each).
REQ-028 ramready outside ISSUE SHALL be ignored.

Reset
REQ-029 On nRST low, asynchronously: state=IDLE, iwait=2'b11, iload0=iload1=0, data register=0, ramREN=0, ramaddr=0, last_grant=1 (core 0 wins first tie).
REQ-030 Reset asserted mid-ISSUE SHALL drop ramREN immediately and discard the pending access; no DONE after release.

Verification
REQ-031 Reset release, iREN=2'b01, iaddr0=0x40, ramready at 2nd cycle, ramload=0xDEADBEEF -> ramaddr=0x40 in ISSUE, iwait=2'b10 one cycle, iload0=0xDEADBEEF.
REQ-032 iREN=2'b11 held, ramready each ISSUE cycle -> grants alternate 0,1,0,1; iwait bits never both low.
REQ-033 dbusy=1 three cycles with iREN=2'b10 -> ramREN stays 0 until cycle after dbusy falls; then normal completion to core 1.
REQ-034 Core 0 in ISSUE, iaddr0 changes 0x40->0x44 before ramready -> abort to IDLE, no iwait low, re-grant with ramaddr=0x44.
REQ-035 iaddr0=0x43 -> ramaddr=0x40.
REQ-036 nRST pulsed during ISSUE with ramready arriving after release -> iwait stays 2'b11, ramREN=0.
